spi_wb_sequencer: RTL and testbench

Wishbone master that sits directly upstream of the SPI master and feeds it one byte per transfer. It accepts byte commands on a valid/ready stream and issues the Wishbone write that starts each SPI transfer. It then tracks the transfer through the SPI master's busy indication and returns the received byte on a valid/ready response stream. Lost-start detection and bounded retry cover the case where the SPI master accepts a write but never begins transmitting.

---
 rtl/spi_wb_sequencer.sv | 175 +++++++++++++++++
 tb/tb_spi_wb_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_sequencer.sv
// Wishbone master that feeds one byte per SPI transfer and returns the received byte,
// with lost-start retry. Define SPI_SEQ_RX_FIFO_EN for a 4-entry rx FIFO (default: single register).
module spi_wb_sequencer #(
   parameter int START_TIMEOUT = 32,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       CLK_I,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   input  logic [1:0] cmd_cs,
   input  logic       cmd_hold,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       err,
   output logic       busy,
   output logic       WE_O,
   output logic       STB_O,
   output logic [7:0] ADR_O,
   output logic [7:0] DAT_O,
   input  logic       ACK_I,
   input  logic       RTY_I,
   input  logic [7:0] DAT_I
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_REQ       = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_CAPTURE   = 3'd4;

   localparam logic [7:0] TIMEOUT_LIM = 8'(START_TIMEOUT);
   localparam logic [2:0] RETRY_LIM   = 3'(MAX_RETRIES);

   logic [2:0] state;
   logic [7:0] timeout_cnt;
   logic [7:0] timeout_nxt;
   logic [2:0] retry_cnt;
   logic       rx_full;
   logic       rx_push;
   logic       rx_pop;
   logic       cmd_take;

   assign busy      = ~reset & (state != ST_IDLE);
   assign cmd_ready = ~reset & (state == ST_IDLE) & ~rx_full;
   assign cmd_take  = cmd_valid & cmd_ready;
   assign rx_push   = (state == ST_CAPTURE);
   assign rx_pop    = rx_valid & rx_ready;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      timeout_nxt = timeout_cnt;
      if (timeout_cnt != 8'hFF) timeout_nxt = timeout_cnt + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK_I) begin
      if (reset) begin
         state       <= ST_IDLE;
         STB_O       <= 1'b0;
         WE_O        <= 1'b0;
         ADR_O       <= 8'h00;
         DAT_O       <= 8'h00;
         timeout_cnt <= 8'h00;
         retry_cnt   <= 3'd0;
         err         <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_take) begin
                  DAT_O     <= cmd_data;
                  ADR_O     <= {cmd_hold, 5'b0, cmd_cs};
                  retry_cnt <= 3'd0;
                  STB_O     <= 1'b1;
                  WE_O      <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (ACK_I) begin
                  STB_O       <= 1'b0;
                  WE_O        <= 1'b0;
                  timeout_cnt <= 8'h00;
                  state       <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (RTY_I) begin
                  state <= ST_WAIT_DONE;
               end else begin
                  timeout_cnt <= timeout_nxt;
                  // The write was accepted but the transfer never began: re-issue or give up.
                  if (timeout_nxt >= TIMEOUT_LIM) begin
                     if (retry_cnt < RETRY_LIM) begin
                        retry_cnt <= retry_cnt + 3'd1;
                        STB_O     <= 1'b1;
                        WE_O      <= 1'b1;
                        state     <= ST_REQ;
                     end else begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!RTY_I) state <= ST_CAPTURE;
            end
            ST_CAPTURE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

`ifdef SPI_SEQ_RX_FIFO_EN
   logic [7:0] rx_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] rx_count;
   logic [2:0] rx_count_nxt;

   // Commands are only accepted in IDLE, so nothing is in flight when the occupancy is tested.
   assign rx_full = rx_count[2];
   assign rx_data = rx_valid ? rx_mem[rd_ptr] : 8'h00;

   always_comb begin
      rx_count_nxt = rx_count;
      case ({rx_push, rx_pop})
         2'b10:   rx_count_nxt = rx_count + 3'd1;
         2'b01:   rx_count_nxt = rx_count - 3'd1;
         default: rx_count_nxt = rx_count;
      endcase
   end

   // NOTE: the storage array is not reset; only pointers and occupancy are, which is all that defines its contents.
   always_ff @(posedge CLK_I) begin
      if (rx_push) rx_mem[wr_ptr] <= DAT_I;
   end

   always_ff @(posedge CLK_I) begin
      if (reset) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         rx_count <= 3'd0;
         rx_valid <= 1'b0;
      end else begin
         if (rx_push) wr_ptr <= wr_ptr + 2'd1;
         if (rx_pop)  rd_ptr <= rd_ptr + 2'd1;
         rx_count <= rx_count_nxt;
         rx_valid <= (rx_count_nxt != 3'd0);
      end
   end
`else
   logic [7:0] rx_data_q;

   assign rx_full = rx_valid;
   assign rx_data = rx_data_q;

   always_ff @(posedge CLK_I) begin
      if (reset) begin
         rx_valid  <= 1'b0;
         rx_data_q <= 8'h00;
      end else if (rx_push) begin
         rx_valid  <= 1'b1;
         rx_data_q <= DAT_I;
      end else if (rx_pop) begin
         rx_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Directed bench for spi_wb_sequencer with a behavioural SPI-master Wishbone responder.
// Expected rx counts follow SPI_SEQ_RX_FIFO_EN when it is defined.
module tb_spi_wb_sequencer;

   logic       CLK_I = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [1:0] cmd_cs;
   logic       cmd_hold;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       err;
   logic       busy;
   logic       WE_O;
   logic       STB_O;
   logic [7:0] ADR_O;
   logic [7:0] DAT_O;
   logic       ACK_I;
   logic       RTY_I;
   logic [7:0] DAT_I;

   always #5 CLK_I = ~CLK_I;

   spi_wb_sequencer #(.START_TIMEOUT(32), .MAX_RETRIES(3)) dut (
      .CLK_I(CLK_I), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .cmd_cs(cmd_cs), .cmd_hold(cmd_hold),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .err(err), .busy(busy),
      .WE_O(WE_O), .STB_O(STB_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
      .ACK_I(ACK_I), .RTY_I(RTY_I), .DAT_I(DAT_I)
   );

   typedef struct {
      logic [7:0] adr;
      logic [7:0] dat;
      int         cyc;
   } wr_t;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   wr_t        wr_log[$];
   logic [7:0] rx_log[$];
   int         err_cnt      = 0;
   int         err_busy_cnt = 0;

   // Responder configuration, written only by the stimulus block.
   int         ack_delay = 1;
   int         busy_len  = 4;
   int         lost_n    = 0;
   int         wr_base   = 0;
   logic [7:0] rx_xor    = 8'h00;

   int m_st  = 0;
   int m_cnt = 0;

   always @(posedge CLK_I) cyc++;

   // SPI master model: ACK after ack_delay, then busy (RTY) for busy_len cycles, unless the write is "lost".
   always @(negedge CLK_I) begin
      ACK_I = 1'b0;
      if (reset) begin
         m_st  = 0;
         RTY_I = 1'b0;
         DAT_I = 8'h00;
      end else begin
         case (m_st)
            0: if (STB_O) begin
               wr_log.push_back('{adr: ADR_O, dat: DAT_O, cyc: cyc});
               if (ack_delay == 0) begin
                  ACK_I = 1'b1;
                  m_st  = 2;
               end else begin
                  m_cnt = ack_delay;
                  m_st  = 1;
               end
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  ACK_I = 1'b1;
                  m_st  = 2;
               end
            end
            2: begin
               if (wr_log.size() - wr_base <= lost_n) begin
                  m_st = 0;
               end else begin
                  RTY_I = 1'b1;
                  DAT_I = DAT_O ^ rx_xor;
                  m_cnt = busy_len;
                  m_st  = 3;
               end
            end
            default: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  RTY_I = 1'b0;
                  m_st  = 0;
               end
            end
         endcase
      end
      if (err) err_cnt++;
      if (err && busy) err_busy_cnt++;
      if (rx_valid && rx_ready) rx_log.push_back(rx_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic push_cmd(input logic [7:0] d, input logic [1:0] cs, input logic h,
                           input int limit, output bit ok);
      int i;
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_cs    = cs;
      cmd_hold  = h;
      ok        = 1'b0;
      i         = 0;
      while (!ok && i < limit) begin
         @(negedge CLK_I);
         ok = cmd_ready;
         tick();
         i++;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      int i;
      ok = 1'b0;
      i  = 0;
      while (!ok && i < limit) begin
         @(negedge CLK_I);
         ok = !busy;
         i++;
      end
      tick();
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      repeat (8) tick();
      rx_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int rx_base;
      int err_base;
      int n_acc;
      int exp_acc;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_cs    = 2'd0;
      cmd_hold  = 1'b0;
      rx_ready  = 1'b0;
      repeat (3) tick();

      // Reset values.
      @(negedge CLK_I);
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_stb",       32'(STB_O), 0);
      check("rst_we",        32'(WE_O), 0);
      check("rst_adr",       32'(ADR_O), 0);
      check("rst_dat",       32'(DAT_O), 0);
      check("rst_rx_valid",  32'(rx_valid), 0);
      check("rst_rx_data",   32'(rx_data), 0);
      check("rst_err",       32'(err), 0);
      check("rst_busy",      32'(busy), 0);
      tick();
      reset = 1'b0;
      tick();

      // Single byte: 0xA5 on cs 2, SPI returns 0x3C.
      ack_delay = 2; busy_len = 40; lost_n = 0; rx_xor = 8'h99;
      wr_base = wr_log.size(); rx_base = rx_log.size(); err_base = err_cnt;
      push_cmd(8'hA5, 2'd2, 1'b0, 20, ok);
      check("t1_accept", 32'(ok), 1);
      wait_idle(200, ok);
      check("t1_done", 32'(ok), 1);
      check("t1_writes", wr_log.size() - wr_base, 1);
      check("t1_adr", 32'(wr_log[wr_base].adr), 'h02);
      check("t1_dat", 32'(wr_log[wr_base].dat), 'hA5);
      @(negedge CLK_I);
      check("t1_rx_valid", 32'(rx_valid), 1);
      check("t1_rx_data", 32'(rx_data), 'h3C);
      check("t1_cmd_ready_full", 32'(cmd_ready), 0);
      tick();
      @(negedge CLK_I);
      check("t1_rx_stable", 32'(rx_data), 'h3C);
      tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      @(negedge CLK_I);
      check("t1_rx_popped", 32'(rx_valid), 0);
      check("t1_rx_count", rx_log.size() - rx_base, 1);
      check("t1_rx_byte", 32'(rx_log[rx_base]), 'h3C);
      check("t1_err", err_cnt - err_base, 0);
      tick();

      // Lost start: first two writes never see busy, third completes.
      ack_delay = 1; busy_len = 5; lost_n = 2; rx_xor = 8'h00;
      wr_base = wr_log.size(); rx_base = rx_log.size(); err_base = err_cnt;
      push_cmd(8'h5A, 2'd1, 1'b0, 20, ok);
      wait_idle(500, ok);
      check("t2_done", 32'(ok), 1);
      check("t2_writes", wr_log.size() - wr_base, 3);
      check("t2_gap1", wr_log[wr_base + 1].cyc - wr_log[wr_base].cyc, 34);
      check("t2_gap2", wr_log[wr_base + 2].cyc - wr_log[wr_base + 1].cyc, 34);
      drain();
      check("t2_rx_count", rx_log.size() - rx_base, 1);
      check("t2_rx_byte", 32'(rx_log[rx_base]), 'h5A);
      check("t2_err", err_cnt - err_base, 0);

      // Retries exhausted: busy never rises.
      lost_n = 1000;
      wr_base = wr_log.size(); rx_base = rx_log.size(); err_base = err_cnt;
      push_cmd(8'h77, 2'd0, 1'b0, 20, ok);
      wait_idle(500, ok);
      check("t3_done", 32'(ok), 1);
      check("t3_writes", wr_log.size() - wr_base, 4);
      check("t3_err_pulses", err_cnt - err_base, 1);
      check("t3_err_with_busy", err_busy_cnt, 0);
      @(negedge CLK_I);
      check("t3_busy", 32'(busy), 0);
      check("t3_err_low", 32'(err), 0);
      check("t3_rx_valid", 32'(rx_valid), 0);
      tick();
      drain();
      check("t3_rx_count", rx_log.size() - rx_base, 0);
      lost_n = 0;

      // Back-pressure: consumer stalled, six commands offered.
`ifdef SPI_SEQ_RX_FIFO_EN
      exp_acc = 4;
`else
      exp_acc = 1;
`endif
      ack_delay = 0; busy_len = 3; rx_xor = 8'hFF;
      wr_base = wr_log.size(); rx_base = rx_log.size();
      n_acc = 0;
      for (int k = 0; k < 6; k++) begin
         push_cmd(8'(8'h10 + k), 2'd0, 1'b0, 60, ok);
         if (ok) n_acc++;
      end
      check("t4_accepted", n_acc, exp_acc);
      @(negedge CLK_I);
      check("t4_cmd_ready_stall", 32'(cmd_ready), 0);
      tick();
      drain();
      check("t4_rx_count", rx_log.size() - rx_base, exp_acc);
      for (int k = 0; k < exp_acc; k++)
         check($sformatf("t4_rx_%0d", k), 32'(rx_log[rx_base + k]), 32'('hEF - k));

      // CS hold across three bytes.
      ack_delay = 1; busy_len = 4; rx_xor = 8'h00;
      wr_base = wr_log.size(); rx_base = rx_log.size();
      rx_ready = 1'b1;
      push_cmd(8'h11, 2'd0, 1'b1, 20, ok);
      wait_idle(100, ok);
      push_cmd(8'h22, 2'd0, 1'b1, 20, ok);
      wait_idle(100, ok);
      push_cmd(8'h33, 2'd0, 1'b0, 20, ok);
      wait_idle(100, ok);
      repeat (3) tick();
      rx_ready = 1'b0;
      check("t5_writes", wr_log.size() - wr_base, 3);
      check("t5_adr0", 32'(wr_log[wr_base].adr), 'h80);
      check("t5_adr1", 32'(wr_log[wr_base + 1].adr), 'h80);
      check("t5_adr2", 32'(wr_log[wr_base + 2].adr), 'h00);
      check("t5_rx_count", rx_log.size() - rx_base, 3);
      check("t5_rx_last", 32'(rx_log[rx_base + 2]), 'h33);

      // Reset while the transfer is in progress (WAIT_DONE).
      ack_delay = 1; busy_len = 40;
      push_cmd(8'h99, 2'd3, 1'b0, 20, ok);
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge CLK_I);
         ok = RTY_I;
         tick();
      end
      check("t6_busy_seen", 32'(ok), 1);
      repeat (3) tick();
      check("t6_in_transfer", 32'(busy), 1);
      reset = 1'b1;
      @(negedge CLK_I);
      check("t6_cmd_ready_rst", 32'(cmd_ready), 0);
      tick();
      reset = 1'b0;
      check("t6_stb", 32'(STB_O), 0);
      check("t6_rx_valid", 32'(rx_valid), 0);
      check("t6_busy", 32'(busy), 0);
      tick();
      ack_delay = 1; busy_len = 5; rx_xor = 8'h0F;
      wr_base = wr_log.size(); rx_base = rx_log.size();
      rx_ready = 1'b1;
      push_cmd(8'h42, 2'd1, 1'b0, 20, ok);
      check("t6_accept", 32'(ok), 1);
      wait_idle(100, ok);
      repeat (3) tick();
      rx_ready = 1'b0;
      check("t6_writes", wr_log.size() - wr_base, 1);
      check("t6_rx_count", rx_log.size() - rx_base, 1);
      check("t6_rx_byte", 32'(rx_log[rx_base]), 'h4D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
